// File: rtl/fanin_req_rr_bridge_pkg.sv
// Shared types and helpers for the bridge request fan-in and the response fan-out.
// The default-width request struct is kept here. The round-robin wrap helper is
// kept here as well so that both sides of the crossbar advance pointers identically.
package fanin_bridge_pkg;

  localparam int BR_ADDR_WIDTH = 32;
  localparam int BR_ID_WIDTH   = 16;
  localparam int BR_DATA_WIDTH = 32;
  localparam int BR_AUX_WIDTH  = 32;
  localparam int BR_BE_WIDTH   = BR_DATA_WIDTH / 8;

  typedef struct packed {
    logic [BR_ADDR_WIDTH-1:0] add;
    logic                     wen;
    logic [BR_DATA_WIDTH-1:0] wdata;
    logic [BR_BE_WIDTH-1:0]   be;
    logic [BR_ID_WIDTH-1:0]   id;
    logic [BR_AUX_WIDTH-1:0]  aux;
  } bridge_req_t;

  // Next round-robin position after serving w among n channels.
  function automatic int unsigned rr_next(input int unsigned w, input int unsigned n);
    return (w == n - 1) ? 32'd0 : w + 32'd1;
  endfunction

endpackage

// File: rtl/fanin_req_rr_bridge_if.sv
// Request/grant bundle of one bridge fan-in port. The slave modport is the bridge
// side, and the master modport is the initiator/target side that drives it.
interface fanin_req_rr_bridge_if
  import fanin_bridge_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int ADDR_WIDTH = BR_ADDR_WIDTH,
  parameter int ID_WIDTH   = BR_ID_WIDTH,
  parameter int DATA_WIDTH = BR_DATA_WIDTH,
  parameter int AUX_WIDTH  = BR_AUX_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int SEL_WIDTH  = $clog2(N_CH)
);
  logic [N_CH-1:0]                 data_req_i;
  logic [N_CH-1:0][ADDR_WIDTH-1:0] data_add_i;
  logic [N_CH-1:0]                 data_wen_i;
  logic [N_CH-1:0][DATA_WIDTH-1:0] data_wdata_i;
  logic [N_CH-1:0][BE_WIDTH-1:0]   data_be_i;
  logic [N_CH-1:0][ID_WIDTH-1:0]   data_ID_i;
  logic [N_CH-1:0][AUX_WIDTH-1:0]  data_aux_i;
  logic [N_CH-1:0]                 data_gnt_o;

  logic                            data_req_o;
  logic [ADDR_WIDTH-1:0]           data_add_o;
  logic                            data_wen_o;
  logic [DATA_WIDTH-1:0]           data_wdata_o;
  logic [BE_WIDTH-1:0]             data_be_o;
  logic [ID_WIDTH-1:0]             data_ID_o;
  logic [AUX_WIDTH-1:0]            data_aux_o;
  logic [SEL_WIDTH-1:0]            data_sel_o;
  logic                            data_gnt_i;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
           data_aux_i, data_gnt_i,
    output data_gnt_o, data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
           data_ID_o, data_aux_o, data_sel_o
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
           data_aux_i, data_gnt_i,
    input  data_gnt_o, data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
           data_ID_o, data_aux_o, data_sel_o
  );
endinterface

// File: rtl/fanin_req_rr_bridge_rr_arb_scan.sv
// rr_arb_scan: combinational round-robin scan. It returns the first set request at
// or above ptr, and wraps from N_CH-1 to 0. When nothing requests, it returns ptr.
// N_CH does not have to be a power of two.
module rr_arb_scan #(
  parameter int N_CH      = 4,
  parameter int SEL_WIDTH = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]      req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] win,
  output logic                 vld
);
  int idx;

  // Scan from farthest to nearest so that the nearest requester is written last and wins.
  always_comb begin
    win = ptr;
    idx = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (req[SEL_WIDTH'(idx)]) win = SEL_WIDTH'(idx);
    end
  end

  assign vld = |req;
endmodule

// File: rtl/fanin_req_rr_bridge.sv
// fanin_req_rr_bridge: N_CH-to-1 request fan-in with internal round-robin priority.
// Optional macro FANIN_REQ_BRIDGE_LOCK_EN: it holds the winner across target stalls
// until the grant arrives. Without the macro, the block re-arbitrates every cycle.
module fanin_req_rr_bridge
  import fanin_bridge_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int ADDR_WIDTH = BR_ADDR_WIDTH,
  parameter int ID_WIDTH   = BR_ID_WIDTH,
  parameter int DATA_WIDTH = BR_DATA_WIDTH,
  parameter int AUX_WIDTH  = BR_AUX_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int SEL_WIDTH  = $clog2(N_CH)
) (
  input logic                  clk,
  input logic                  rst_n,
  fanin_req_rr_bridge_if.slave bus
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic [ID_WIDTH-1:0]   id;
    logic [AUX_WIDTH-1:0]  aux;
  } req_t;

  logic [SEL_WIDTH-1:0] rr_ptr_q;
  logic [SEL_WIDTH-1:0] scan_win;
  logic [SEL_WIDTH-1:0] win;
  logic                 scan_vld;
  logic                 hs;
  req_t                 pay [N_CH];
  req_t                 win_pay;

  rr_arb_scan #(.N_CH(N_CH), .SEL_WIDTH(SEL_WIDTH)) u_scan (
    .req (bus.data_req_i),
    .ptr (rr_ptr_q),
    .win (scan_win),
    .vld (scan_vld)
  );

`ifdef FANIN_REQ_BRIDGE_LOCK_EN
  logic                 lock_q;
  logic [SEL_WIDTH-1:0] lock_ch_q;
  logic                 lock_hit;

  // The lock only applies while the locked channel still requests. A dropped request
  // falls back to the normal scan.
  assign lock_hit = lock_q & bus.data_req_i[lock_ch_q];
  assign win      = lock_hit ? lock_ch_q : scan_win;

  // Capture the winner on a stall. Release the lock on a handshake or when the requests go idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else if (scan_vld && !bus.data_gnt_i) begin
      lock_q    <= 1'b1;
      lock_ch_q <= win;
    end else begin
      lock_q    <= 1'b0;
    end
  end
`else
  assign win = scan_win;
`endif

  assign hs = scan_vld & bus.data_gnt_i;

  // After the served channel, the pointer moves one past it. That channel then has the lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rr_ptr_q <= '0;
    else if (hs) rr_ptr_q <= SEL_WIDTH'(rr_next(32'(win), N_CH));
  end

  // Pack each channel's payload so the winner mux is a single select.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      pay[c] = '{add:   bus.data_add_i[c],   wen: bus.data_wen_i[c],
                 wdata: bus.data_wdata_i[c], be:  bus.data_be_i[c],
                 id:    bus.data_ID_i[c],    aux: bus.data_aux_i[c]};
    end
  end

  assign win_pay = pay[win];

  // The grant goes only to the winner, and only when it really requests.
  always_comb begin
    bus.data_gnt_o      = '0;
    bus.data_gnt_o[win] = bus.data_req_i[win] & bus.data_gnt_i;
  end

  assign bus.data_req_o   = scan_vld;
  assign bus.data_sel_o   = win;
  assign bus.data_add_o   = win_pay.add;
  assign bus.data_wen_o   = win_pay.wen;
  assign bus.data_wdata_o = win_pay.wdata;
  assign bus.data_be_o    = win_pay.be;
  assign bus.data_ID_o    = win_pay.id;
  assign bus.data_aux_o   = win_pay.aux;
endmodule

// File: tb/tb_fanin_req_rr_bridge.sv
// Scoreboard bench for fanin_req_rr_bridge: a 4-channel instance and a 3-channel instance.
// The driver pushes the modelled combinational response of each cycle. The monitor pops
// and compares on the falling edge.
module tb_fanin_req_rr_bridge;
`ifdef FANIN_REQ_BRIDGE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fanin_req_rr_bridge_if #(.N_CH(4)) b4 ();
  fanin_req_rr_bridge_if #(.N_CH(3)) b3 ();

  fanin_req_rr_bridge #(.N_CH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  fanin_req_rr_bridge #(.N_CH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  typedef struct {
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [15:0] id;
    logic [31:0] aux;
  } pay_t;

  typedef struct {
    logic       req;
    logic [3:0] gnt;
    logic [1:0] sel;
    pay_t       p;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: one set per instance
  int ptr [2];
  bit lk  [2];
  int lkc [2];
  int nch [2] = '{4, 3};

  function automatic pay_t mk_pay(input int s, input int d, input int c);
    pay_t p;
    logic [31:0] h;
    h       = 32'(s) * 32'h9E3779B1 + 32'(d * 16 + c + 1) * 32'h85EBCA6B;
    p.add   = h;
    p.wen   = h[3];
    p.wdata = ~h ^ 32'(c);
    p.be    = h[7:4];
    p.id    = h[31:16] ^ 16'(c);
    p.aux   = {h[15:0], h[31:16]};
    return p;
  endfunction

  // The winner is the locked channel if it still requests. Otherwise it is the first
  // requester at or after ptr, going round the ring. If nobody requests, it is ptr.
  function automatic int pick(input int n, input logic [3:0] req, input int p,
                              input bit l, input int lc);
    if (l && req[2'(lc)]) return lc;
    for (int k = 0; k < n; k++)
      if (req[2'((p + k) % n)]) return (p + k) % n;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic [3:0] req, input logic gi, input int s);
    exp_t e;
    pay_t p;
    int   w;
    if (!rst_n) begin
      ptr[d] = 0; lk[d] = 1'b0; lkc[d] = 0;
    end
    for (int c = 0; c < nch[d]; c++) begin
      p = mk_pay(s, d, c);
      if (d == 0) begin
        b4.data_add_i[2'(c)] = p.add;   b4.data_wen_i[2'(c)] = p.wen;
        b4.data_wdata_i[2'(c)] = p.wdata; b4.data_be_i[2'(c)] = p.be;
        b4.data_ID_i[2'(c)] = p.id;     b4.data_aux_i[2'(c)] = p.aux;
      end else begin
        b3.data_add_i[2'(c)] = p.add;   b3.data_wen_i[2'(c)] = p.wen;
        b3.data_wdata_i[2'(c)] = p.wdata; b3.data_be_i[2'(c)] = p.be;
        b3.data_ID_i[2'(c)] = p.id;     b3.data_aux_i[2'(c)] = p.aux;
      end
    end
    if (d == 0) begin b4.data_req_i = req;      b4.data_gnt_i = gi; end
    else        begin b3.data_req_i = req[2:0]; b3.data_gnt_i = gi; end

    w             = pick(nch[d], req, ptr[d], LOCK && lk[d], lkc[d]);
    e.req         = |req;
    e.gnt         = '0;
    e.gnt[2'(w)]  = req[2'(w)] & gi;
    e.sel         = 2'(w);
    e.p           = mk_pay(s, d, w);
    if (d == 0) q4.push_back(e); else q3.push_back(e);

    // State as seen after the coming edge, unless reset holds it
    if (rst_n) begin
      if ((|req) && gi) ptr[d] = (w == nch[d] - 1) ? 0 : w + 1;
      lk[d] = (|req) && !gi;
      if (lk[d]) lkc[d] = w;
    end
  endtask

  task automatic step(input logic [3:0] r4, input logic g4,
                      input logic [2:0] r3, input logic g3, input int s);
    drive(0, r4, g4, s);
    drive(1, {1'b0, r3}, g3, s);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT outputs against the expectation pushed for this cycle
  always @(negedge clk) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("req4",   64'(b4.data_req_o),   64'(e.req));
      chk("gnt4",   64'(b4.data_gnt_o),   64'(e.gnt));
      chk("sel4",   64'(b4.data_sel_o),   64'(e.sel));
      chk("add4",   64'(b4.data_add_o),   64'(e.p.add));
      chk("wen4",   64'(b4.data_wen_o),   64'(e.p.wen));
      chk("wdata4", 64'(b4.data_wdata_o), 64'(e.p.wdata));
      chk("be4",    64'(b4.data_be_o),    64'(e.p.be));
      chk("id4",    64'(b4.data_ID_o),    64'(e.p.id));
      chk("aux4",   64'(b4.data_aux_o),   64'(e.p.aux));
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      chk("req3", 64'(b3.data_req_o), 64'(e.req));
      chk("gnt3", 64'(b3.data_gnt_o), 64'(e.gnt));
      chk("sel3", 64'(b3.data_sel_o), 64'(e.sel));
      chk("add3", 64'(b3.data_add_o), 64'(e.p.add));
      chk("id3",  64'(b3.data_ID_o),  64'(e.p.id));
    end
  end

  initial begin
    rst_n = 1'b0;
    b4.data_req_i = '0; b4.data_gnt_i = 1'b0;
    b3.data_req_i = '0; b3.data_gnt_i = 1'b0;
    @(posedge clk);
    #1;

    // Reset state with idle requests
    step(4'b0000, 1'b0, 3'b000, 1'b0, 1);
    step(4'b0000, 1'b1, 3'b000, 1'b1, 2);
    rst_n = 1'b1;

    // Rotation on 4 channels. On 3 channels: move the pointer to 2, then wrap 2,0,2.
    step(4'b1111, 1'b1, 3'b010, 1'b1, 3);
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 3'b101, 1'b1, 4 + i);
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 3'b000, 1'b0, 7 + i);

    // Lock: pointer to 1, then ch0+ch1 stall 3 cycles, then grant ch1, then ch0 is served next
    step(4'b0001, 1'b1, 3'b011, 1'b0, 20);
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b0, 3'b011, 1'b0, 21);
    step(4'b0011, 1'b1, 3'b011, 1'b1, 21);
    step(4'b0011, 1'b1, 3'b110, 1'b1, 22);

    // Late higher-priority arrival during a stall of ch3 with the pointer at 2
    step(4'b0010, 1'b1, 3'b001, 1'b1, 30);
    step(4'b1000, 1'b0, 3'b100, 1'b0, 31);
    step(4'b1100, 1'b0, 3'b110, 1'b0, 31);
    step(4'b1100, 1'b1, 3'b110, 1'b1, 31);

    // Reset in the middle of a stall locked on ch2
    step(4'b0010, 1'b1, 3'b010, 1'b1, 40);
    step(4'b0110, 1'b0, 3'b110, 1'b0, 41);
    step(4'b0110, 1'b0, 3'b110, 1'b0, 41);
    rst_n = 1'b0;
    step(4'b0110, 1'b0, 3'b110, 1'b0, 41);
    rst_n = 1'b1;
    step(4'b0110, 1'b1, 3'b110, 1'b1, 41);

    // Random traffic: bursts of held payloads and occasional stalls
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), ($urandom_range(0, 3) != 0), 3'($urandom),
           ($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)) + 100 * (i / 5));
    end

    step(4'b0000, 1'b0, 3'b000, 1'b0, 0);
    @(negedge clk);
    #1;
    chk("drain", 64'(q4.size() + q3.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
